div_ctrl: RTL and testbench

Multi-cycle iterative divider and controller for DIV/DIVU in the execute stage. It accepts a start request from ex and runs a radix-2 restoring division over WIDTH cycles. While the result is pending it raises a stall request to the pipeline. It returns {remainder, quotient} for the HI/LO write path, and aborts cleanly when the pipeline flushes for an exception.

---
 rtl/div_ctrl.sv | 146 ++++++++++++++
 tb/tb_div_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle radix-2 restoring divider for DIV/DIVU.
// Produces {remainder, quotient} for the HI/LO write path, holds a stall
// request while the result is pending, and abandons work on a pipeline flush.
module div_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               annul_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   op1_i,
    input  logic [WIDTH-1:0]   op2_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stallreq_o
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        DIVZERO,
        BUSY,
        DONE
    } state_t;

    state_t state, state_n;

    // Dividend register doubles as the quotient: bits shift out the top
    // while quotient bits shift in at the bottom.
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] rem;
    logic [CNT_W-1:0] cnt;
    logic             sgn_op;
    logic             op1_neg;
    logic             sign_diff;

    logic             accept;
    logic             last_step;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_sub;
    logic             q_bit;
    logic [WIDTH-1:0] rem_n;
    logic [WIDTH-1:0] quo_n;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] abs1;
    logic [WIDTH-1:0] abs2;

    assign accept     = start_i && !annul_i;
    assign last_step  = (cnt == CNT_W'(WIDTH - 1));
    assign stallreq_o = start_i && !ready_o;

    // Operand magnitudes at accept and one restoring step with sign fix-up.
    always_comb begin
        abs1    = (signed_i && op1_i[WIDTH-1]) ? -op1_i : op1_i;
        abs2    = (signed_i && op2_i[WIDTH-1]) ? -op2_i : op2_i;
        rem_sh  = {rem, dividend[WIDTH-1]};
        rem_sub = rem_sh - {1'b0, divisor};
        q_bit   = (rem_sh >= {1'b0, divisor});
        rem_n   = q_bit ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_n   = {dividend[WIDTH-2:0], q_bit};
        quo_fix = (sgn_op && sign_diff) ? -quo_n : quo_n;
        rem_fix = (sgn_op && op1_neg)   ? -rem_n : rem_n;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state logic; a flush overrides every other transition.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = (op2_i == '0) ? DIVZERO : BUSY;
            DIVZERO: state_n = DONE;
            BUSY:    if (last_step) state_n = DONE;
            DONE:    if (!start_i) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (annul_i) state_n = IDLE;
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            dividend  <= '0;
            divisor   <= '0;
            rem       <= '0;
            cnt       <= '0;
            sgn_op    <= 1'b0;
            op1_neg   <= 1'b0;
            sign_diff <= 1'b0;
            result_o  <= '0;
            ready_o   <= 1'b0;
        end else if (annul_i) begin
            cnt      <= '0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    result_o <= '0;
                    ready_o  <= 1'b0;
                    if (start_i && op2_i != '0) begin
                        dividend  <= abs1;
                        divisor   <= abs2;
                        rem       <= '0;
                        cnt       <= '0;
                        sgn_op    <= signed_i;
                        op1_neg   <= op1_i[WIDTH-1];
                        sign_diff <= op1_i[WIDTH-1] ^ op2_i[WIDTH-1];
                    end
                end
                DIVZERO: begin
                    result_o <= '0;
                    ready_o  <= 1'b1;
                end
                BUSY: begin
                    dividend <= quo_n;
                    rem      <= rem_n;
                    cnt      <= cnt + CNT_W'(1);
                    if (last_step) begin
                        result_o <= {rem_fix, quo_fix};
                        ready_o  <= 1'b1;
                    end
                end
                DONE: begin
                    if (!start_i) begin
                        result_o <= '0;
                        ready_o  <= 1'b0;
                    end
                end
                default: begin
                    result_o <= '0;
                    ready_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed vectors with hand-computed results for div_ctrl.
module tb_div_ctrl;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        annul_i;
    logic        signed_i;
    logic [31:0] op1_i;
    logic [31:0] op2_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    int n_tests = 0;
    int n_fail  = 0;

    div_ctrl #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .annul_i    (annul_i),
        .signed_i   (signed_i),
        .op1_i      (op1_i),
        .op2_i      (op2_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .stallreq_o (stallreq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Run one division with start held, optionally scrambling operands mid-run.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic [63:0] exp_res, input int exp_stall,
                           input bit scramble);
        int cycles;
        cycles = 0;
        @(negedge clk);
        op1_i = a; op2_i = b; signed_i = s; start_i = 1'b1;
        #1;
        for (int i = 0; i < 100 && !ready_o; i++) begin
            if (stallreq_o) cycles++;
            if (scramble && i == 3) begin
                op1_i = 32'hDEAD_BEEF; op2_i = 32'h0000_0005; signed_i = ~s;
            end
            @(negedge clk); #1;
        end
        check({tag, " stall"}, 64'(cycles), 64'(exp_stall));
        check({tag, " ready"}, 64'(ready_o), 64'd1);
        check({tag, " result"}, result_o, exp_res);
        check({tag, " stallreq_done"}, 64'(stallreq_o), 64'd0);
        @(negedge clk); #1;
        check({tag, " hold"}, {63'd0, ready_o}, 64'd1);
        start_i = 1'b0;
        @(negedge clk); #1;
        check({tag, " drop_ready"}, 64'(ready_o), 64'd0);
        check({tag, " drop_result"}, result_o, 64'd0);
    endtask

    initial begin
        int seen;
        logic [63:0] captured;
        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_i = 1'b0;
        op1_i = '0; op2_i = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset ready", 64'(ready_o), 64'd0);
        check("reset result", result_o, 64'd0);
        check("reset stallreq", 64'(stallreq_o), 64'd0);
        rst = 1'b0;

        run_div("divu 100/7", 32'd100, 32'd7, 1'b0, {32'h2, 32'hE}, 33, 1'b0);
        run_div("div -7/2", 32'hFFFF_FFF9, 32'h2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 1'b0);
        run_div("div 7/-2", 32'h7, 32'hFFFF_FFFE, 1'b1, {32'h1, 32'hFFFF_FFFD}, 33, 1'b0);
        run_div("divu big/2", 32'hFFFF_FFF9, 32'h2, 1'b0, {32'h1, 32'h7FFF_FFFC}, 33, 1'b0);
        run_div("divu max/c0", 32'hFFFF_FFFF, 32'hC000_0000, 1'b0, {32'h3FFF_FFFF, 32'h1}, 33, 1'b0);
        run_div("divu by0", 32'd55, 32'd0, 1'b0, 64'd0, 2, 1'b0);
        run_div("div ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0, 32'h8000_0000}, 33, 1'b0);
        run_div("stable", 32'd100, 32'd7, 1'b0, {32'h2, 32'hE}, 33, 1'b1);

        // Flush at BUSY cycle 10 with start still high: no result may follow.
        @(negedge clk);
        op1_i = 32'd1000; op2_i = 32'd3; signed_i = 1'b0; start_i = 1'b1;
        repeat (11) @(negedge clk);
        annul_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b0; start_i = 1'b0;
        #1;
        check("annul ready", 64'(ready_o), 64'd0);
        check("annul result", result_o, 64'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (ready_o) seen++;
        end
        check("annul no_ready", 64'(seen), 64'd0);
        run_div("after annul 9/3", 32'd9, 32'd3, 1'b0, {32'h0, 32'h3}, 33, 1'b0);

        // Reset at BUSY cycle 20.
        @(negedge clk);
        op1_i = 32'd100; op2_i = 32'd7; signed_i = 1'b0; start_i = 1'b1;
        repeat (21) @(negedge clk);
        rst = 1'b1; start_i = 1'b0;
        @(negedge clk); #1;
        check("midrst ready", 64'(ready_o), 64'd0);
        check("midrst result", result_o, 64'd0);
        check("midrst stallreq", 64'(stallreq_o), 64'd0);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (ready_o) seen++;
        end
        check("midrst no_ready", 64'(seen), 64'd0);
        run_div("after rst 100/7", 32'd100, 32'd7, 1'b0, {32'h2, 32'hE}, 33, 1'b0);

        // start dropped during BUSY: single ready pulse carrying the result.
        @(negedge clk);
        op1_i = 32'd50; op2_i = 32'd6; signed_i = 1'b0; start_i = 1'b1;
        repeat (5) @(negedge clk);
        start_i = 1'b0;
        seen = 0; captured = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (ready_o) begin seen++; captured = result_o; end
        end
        check("drop pulse", 64'(seen), 64'd1);
        check("drop result", captured, {32'h2, 32'h8});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
